// File: rtl/shift_reg_cnt.sv
// shift_reg_cnt: loadable shift register with a saturating shift counter.
// A load starts a session. Each shift during the session advances cnt.
// The WIDTH-th shift ends the session and produces a one-cycle done pulse.
// Outside a session the register still shifts, but cnt stays parked at WIDTH.
// WIDTH is intended to lie in 2..32.
module shift_reg_cnt #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               MSB_FIRST = 1'b0,
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic             sh,
   input  logic             sin,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             sout,
   output logic [CW-1:0]    cnt,
   output logic             busy,
   output logic             done
);

   // cnt == CNT_IDLE means no session is running.
   localparam logic [CW-1:0] CNT_IDLE = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_shift;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // The bit order fixes both the shift direction and which end feeds sout.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign q_shift = {Q[WIDTH-2:0], sin};
         assign sout    = Q[WIDTH-1];
      end else begin : g_lsb_first
         assign q_shift = {sin, Q[WIDTH-1:1]};
         assign sout    = Q[0];
      end
   endgenerate

   // Next-state selection: ld wins over sh. The counter only runs inside a session.
   always_comb begin
      q_nxt    = Q;
      cnt_nxt  = cnt;
      busy_nxt = busy;
      done_nxt = 1'b0;
      if (ld) begin
         q_nxt    = D;
         cnt_nxt  = '0;
         busy_nxt = 1'b1;
      end else if (sh) begin
         q_nxt = q_shift;
         if (busy) begin
            cnt_nxt = cnt + CW'(1);
            // The final shift of the session clears busy and raises done on the same edge.
            if (cnt == CNT_LAST) begin
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
            end
         end
      end
   end

   // State registers. The asynchronous reset returns the block to idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Q    <= RESET_VAL;
         cnt  <= CNT_IDLE;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         Q    <= q_nxt;
         cnt  <= cnt_nxt;
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

endmodule

// File: doc/shift_reg_cnt.md
# shift_reg_cnt

Parametrised loadable shift register with a built-in shift counter, the general-purpose datapath register for the UART transmit and receive paths. It keeps the loadable-register behaviour and adds serial shift in either bit order, serial in/out, a saturating shift counter, and busy/done status. TX uses it as a parallel-in/serial-out (PISO) register. RX uses it as a serial-in/parallel-out (SIPO) register by arming it with a load.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value of Q after reset, WIDTH bits.
- MSB_FIRST, 0, bit order: 0 = shift right, LSB out first; 1 = shift left, MSB out first.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ld  input  1  parallel load and session start.
- sh  input  1  shift enable, one bit per cycle while high.
- sin  input  1  serial input bit, entered on each shift.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- sout  output  1  serial output bit, combinational from Q.
- cnt  output  CW = $clog2(WIDTH+1)  shifts completed since the last ld.
- busy  output  1  session in progress.
- done  output  1  one-cycle pulse when a session completes.

## Operation
- Reset values: Q = RESET_VAL, cnt = WIDTH (idle), busy = 0, done = 0.
- Priority at each rising edge: reset, then ld, then sh, then hold.
- ld = 1 (sh is ignored in the same cycle):
  - Q <= D, cnt <= 0, busy <= 1, done <= 0.
  - A load while busy restarts the session; no done pulse is produced for the aborted session.
- sh = 1 with ld = 0, shift data:
  - MSB_FIRST = 0: Q <= {sin, Q[WIDTH-1:1]}.
  - MSB_FIRST = 1: Q <= {Q[WIDTH-2:0], sin}.
- sh = 1 with ld = 0, counting:
  - Only while busy: cnt <= cnt + 1.
  - On the shift that takes cnt from WIDTH-1 to WIDTH: busy <= 0 and done <= 1 on that same edge.
- Shifting while idle still moves data through Q. cnt stays saturated at WIDTH and done stays 0.
- done is registered. It is high for exactly one cycle and clears on the next edge unless a new completion occurs on that edge, which is impossible because a restart needs ld.
- sout: Q[0] when MSB_FIRST = 0, Q[WIDTH-1] when MSB_FIRST = 1. It presents the next bit to leave, updates with Q, and has no extra register stage.
- busy equals (cnt != WIDTH). It is implemented as a register and must always agree with that expression.
- No ld and no sh: all state holds, and done falls to 0.

## Timing
- Load latency: Q = D and busy = 1 are visible in the cycle after the edge where ld was sampled.
- Session length:
  - Exactly WIDTH cycles with sh = 1 after the load edge, not necessarily consecutive. Gaps with sh = 0 pause the count.
  - done appears after the edge of the WIDTH-th shift. With ld at edge 0 and sh high continuously, done is high during the cycle after edge WIDTH.
- Receive use: after the final shift, Q holds the last WIDTH sin bits and is valid in the same cycle done is high.
- Back-to-back sessions: ld may be asserted in the cycle done is high. The new session starts on that edge and done clears.
- Asynchronous reset:
  - Reset mid-session forces the reset values immediately, with no clock needed.
  - On the first edge after reset deasserts, normal priority applies.
- sin, ld, sh and D are synchronous inputs. The bench drives them away from the rising edge.

## Test plan
- **Reset:** assert reset mid-session → Q = RESET_VAL, cnt = WIDTH, busy = 0, done = 0 immediately. Deassert → state holds until ld.
- **PISO:** WIDTH = 8, MSB_FIRST = 0, ld with D = 0xA5, then 8 shifts with sin = 1.
  - sout sequence is 1,0,1,0,0,1,0,1.
  - done pulses once after the 8th shift.
  - Q = 0xFF, cnt = 8, busy = 0.
- **SIPO:** MSB_FIRST = 1, ld with D = 0x00, then shift in sin = 1,1,0,0,1,0,1,0.
  - Q = 0xCA.
  - done is high in the same cycle Q first reads 0xCA.
- **Pause, then simultaneous ld and sh:**
  - ld, then 3 shifts, then 5 idle cycles → cnt = 3, busy = 1.
  - Assert ld and sh together with D = 0x3C → Q = 0x3C, cnt = 0, no shift.
- **Restart and idle shift:**
  - Reload at cnt = 6 → no done pulse; a full 8 shifts are then required.
  - Shifts while idle move Q, while cnt stays at 8 and done stays 0.
- **Parameter sweep:** WIDTH = 2, 11 and 32 with both MSB_FIRST values.
  - done arrives after exactly WIDTH shifts.
  - cnt never exceeds WIDTH.
  - busy == (cnt != WIDTH) every cycle.
